// File: rtl/wbq_pkg.sv
// wbq_pkg: shared definitions for the register-file write queue.
//   DEPTH_DEF / REGW_DEF / DATAW_DEF : default queue depth and field widths
//   REG_ZERO  : the hardwired-zero register number; writes to it are discarded
//   entry_t   : one queued writeback (destination register + data)
//   ptr_width : width of a head/tail pointer for a given depth
package wbq_pkg;

  localparam int DEPTH_DEF = 4;
  localparam int REGW_DEF  = 5;
  localparam int DATAW_DEF = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [REGW_DEF-1:0]  regn;
    logic [DATAW_DEF-1:0] data;
  } entry_t;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wbq_fwd_lookup.sv
// wbq_fwd_lookup: combinational forwarding search over the queued entries.
//   regn_q / data_q : entry storage (indexed by slot)
//   head / count    : first occupied slot and number of occupied slots
//   rdn             : register number being read by the operand stage
//   hit / data      : youngest queued entry for rdn (data is 0 on a miss)
module wbq_fwd_lookup
  import wbq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int REGW  = REGW_DEF,
  parameter int DATAW = DATAW_DEF,
  parameter int PTRW  = ptr_width(DEPTH)
) (
  input  logic [DEPTH-1:0][REGW-1:0]  regn_q,
  input  logic [DEPTH-1:0][DATAW-1:0] data_q,
  input  logic [PTRW-1:0]             head,
  input  logic [PTRW:0]               count,
  input  logic [REGW-1:0]             rdn,
  output logic                        hit,
  output logic [DATAW-1:0]            data
);

  logic [PTRW-1:0] idx;

  // Walk from the oldest entry toward the youngest; a later match simply
  // overrides an earlier one, which gives the same result as a priority
  // search from tail-1 back to head. Register 0 never forwards.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PTRW'(i);
      if (((PTRW+1)'(i) < count) && (rdn != REGW'(REG_ZERO)) &&
          (regn_q[idx] == rdn)) begin
        hit  = 1'b1;
        data = data_q[idx];
      end
    end
  end

endmodule

// File: rtl/regfile_write_queue.sv
// regfile_write_queue: in-order write buffer in front of the register file.
//   clk, reset          : rising-edge clock, synchronous active-low reset
//   alu_*               : ALU writeback, always accepted (lost only if no slot)
//   mem_* / mem_ready   : load/multiply writeback with valid/ready handshake
//   wregn / wdata / wen : register-file write port, driven from the head entry
//   rd1n / rd2n, fwd*   : forwarding lookups into the queued (uncommitted) data
//   count               : occupied entries
//   err_ovf             : sticky flag, an ALU result was dropped
module regfile_write_queue
  import wbq_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int REGW  = REGW_DEF,
  parameter int DATAW = DATAW_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       alu_valid,
  input  logic [REGW-1:0]            alu_regn,
  input  logic [DATAW-1:0]           alu_data,
  input  logic                       mem_valid,
  output logic                       mem_ready,
  input  logic [REGW-1:0]            mem_regn,
  input  logic [DATAW-1:0]           mem_data,
  output logic [REGW-1:0]            wregn,
  output logic [DATAW-1:0]           wdata,
  output logic                       wen,
  input  logic [REGW-1:0]            rd1n,
  output logic                       fwd1_hit,
  output logic [DATAW-1:0]           fwd1_data,
  input  logic [REGW-1:0]            rd2n,
  output logic                       fwd2_hit,
  output logic [DATAW-1:0]           fwd2_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       err_ovf
);

  localparam int PTRW = ptr_width(DEPTH);
  localparam int CNTW = $clog2(DEPTH) + 1;

  logic [DEPTH-1:0][REGW-1:0]  regn_q;
  logic [DEPTH-1:0][DATAW-1:0] data_q;
  logic [PTRW-1:0]             head;
  logic [PTRW-1:0]             tail;
  logic [CNTW-1:0]             count_q;
  logic                        err_q;

  logic                        pop;
  logic [CNTW:0]               free;
  logic                        alu_req;
  logic                        alu_take;
  logic                        mem_push;
  logic [PTRW-1:0]             mem_slot;
  entry_t                      alu_entry;
  entry_t                      mem_entry;

  assign alu_entry = '{regn: alu_regn, data: alu_data};
  assign mem_entry = '{regn: mem_regn, data: mem_data};

  // The head always drains when occupied, so its slot counts as free for
  // this cycle's pushes.
  assign pop  = (count_q != '0);
  assign free = (CNTW+1)'(DEPTH) - {1'b0, count_q} + {{CNTW{1'b0}}, pop};

  // Writes to register 0 are swallowed without occupying a slot.
  assign alu_req   = alu_valid && (alu_regn != REGW'(REG_ZERO));
  assign alu_take  = alu_req && (free != '0);
  assign mem_ready = reset && ((free - {{CNTW{1'b0}}, alu_take}) != '0);
  assign mem_push  = mem_valid && mem_ready && (mem_regn != REGW'(REG_ZERO));

  // When both sources push, the ALU result is the older of the two.
  assign mem_slot = tail + PTRW'(alu_take);

  // Storage needs no reset; only slots between head and tail are ever read.
  always_ff @(posedge clk) begin
    if (alu_take) begin
      regn_q[tail] <= alu_entry.regn;
      data_q[tail] <= alu_entry.data;
    end
    if (mem_push) begin
      regn_q[mem_slot] <= mem_entry.regn;
      data_q[mem_slot] <= mem_entry.data;
    end
  end

  // Pointer, occupancy and overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head    <= head + PTRW'(pop);
      tail    <= tail + PTRW'(alu_take) + PTRW'(mem_push);
      count_q <= count_q + CNTW'(alu_take) + CNTW'(mem_push) - CNTW'(pop);
      if (alu_req && !alu_take) begin
        err_q <= 1'b1;
      end
    end
  end

  assign wen     = pop;
  assign wregn   = pop ? regn_q[head] : '0;
  assign wdata   = pop ? data_q[head] : '0;
  assign count   = count_q;
  assign err_ovf = err_q;

  wbq_fwd_lookup #(.DEPTH(DEPTH), .REGW(REGW), .DATAW(DATAW), .PTRW(PTRW)) u_fwd1 (
    .regn_q (regn_q),
    .data_q (data_q),
    .head   (head),
    .count  (count_q),
    .rdn    (rd1n),
    .hit    (fwd1_hit),
    .data   (fwd1_data)
  );

  wbq_fwd_lookup #(.DEPTH(DEPTH), .REGW(REGW), .DATAW(DATAW), .PTRW(PTRW)) u_fwd2 (
    .regn_q (regn_q),
    .data_q (data_q),
    .head   (head),
    .count  (count_q),
    .rdn    (rd2n),
    .hit    (fwd2_hit),
    .data   (fwd2_data)
  );

endmodule

// File: tb/tb_regfile_write_queue.sv
// tb_regfile_write_queue: randomized and directed stimulus for
// regfile_write_queue, checked against a queue-based reference model and a
// register-file image rebuilt from the DUT write port.
module tb_regfile_write_queue;

  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } ent_t;

  logic        clk;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_regn;
  logic [31:0] alu_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [4:0]  mem_regn;
  logic [31:0] mem_data;
  logic [4:0]  wregn;
  logic [31:0] wdata;
  logic        wen;
  logic [4:0]  rd1n;
  logic        fwd1_hit;
  logic [31:0] fwd1_data;
  logic [4:0]  rd2n;
  logic        fwd2_hit;
  logic [31:0] fwd2_data;
  logic [2:0]  count;
  logic        err_ovf;

  int          checks;
  int          failures;
  ent_t        model_q[$];
  logic [31:0] model_rf[32];
  logic [31:0] dut_rf[32];
  logic        model_err;
  int          max_count;

  regfile_write_queue #(.DEPTH(DEPTH), .REGW(5), .DATAW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_valid),
    .alu_regn  (alu_regn),
    .alu_data  (alu_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_regn  (mem_regn),
    .mem_data  (mem_data),
    .wregn     (wregn),
    .wdata     (wdata),
    .wen       (wen),
    .rd1n      (rd1n),
    .fwd1_hit  (fwd1_hit),
    .fwd1_data (fwd1_data),
    .rd2n      (rd2n),
    .fwd2_hit  (fwd2_hit),
    .fwd2_data (fwd2_data),
    .count     (count),
    .err_ovf   (err_ovf)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Youngest stored entry for a register; register 0 never hits.
  task automatic modelLookup(input logic [4:0] rn, output logic hit, output logic [31:0] data);
    hit  = 1'b0;
    data = 32'h0;
    if (rn != 5'd0) begin
      foreach (model_q[i]) begin
        if (model_q[i].r == rn) begin
          hit  = 1'b1;
          data = model_q[i].d;
        end
      end
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check the
  // combinational outputs against the model, then advance the model and the
  // register-file image across the rising edge.
  task automatic applyStimulus(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                               input logic mv, input logic [4:0] mr, input logic [31:0] md,
                               input logic [4:0] r1, input logic [4:0] r2, input logic rst);
    int          e_free;
    logic        e_take;
    logic        e_ready;
    logic        h1, h2;
    logic [31:0] d1, d2;
    logic        pend;
    logic [4:0]  pr;
    logic [31:0] pd;
    ent_t        e;

    @(negedge clk);
    alu_valid = av;  alu_regn = ar;  alu_data = ad;
    mem_valid = mv;  mem_regn = mr;  mem_data = md;
    rd1n = r1;  rd2n = r2;  reset = rst;
    #1;

    e_free  = DEPTH - model_q.size() + ((model_q.size() != 0) ? 1 : 0);
    e_take  = av && (ar != 5'd0) && (e_free >= 1);
    e_ready = rst && ((e_free - (e_take ? 1 : 0)) >= 1);
    modelLookup(r1, h1, d1);
    modelLookup(r2, h2, d2);

    checkOutput("wen", 64'(wen), 64'(model_q.size() != 0));
    checkOutput("wregn", 64'(wregn), (model_q.size() != 0) ? 64'(model_q[0].r) : 64'h0);
    checkOutput("wdata", 64'(wdata), (model_q.size() != 0) ? 64'(model_q[0].d) : 64'h0);
    checkOutput("count", 64'(count), 64'(model_q.size()));
    checkOutput("mem_ready", 64'(mem_ready), 64'(e_ready));
    checkOutput("err_ovf", 64'(err_ovf), 64'(model_err));
    checkOutput("fwd1_hit", 64'(fwd1_hit), 64'(h1));
    checkOutput("fwd1_data", 64'(fwd1_data), 64'(d1));
    checkOutput("fwd2_hit", 64'(fwd2_hit), 64'(h2));
    checkOutput("fwd2_data", 64'(fwd2_data), 64'(d2));

    pend = wen;
    pr   = wregn;
    pd   = wdata;

    @(posedge clk);
    #1;
    if (pend === 1'b1) dut_rf[pr] = pd;

    if (model_q.size() != 0) begin
      e = model_q.pop_front();
      model_rf[e.r] = e.d;
    end
    if (!rst) begin
      model_q.delete();
      model_err = 1'b0;
    end else begin
      if (av && ar != 5'd0) begin
        if (e_free >= 1) model_q.push_back('{r: ar, d: ad});
        else             model_err = 1'b1;
      end
      if (mv && e_ready && mr != 5'd0) model_q.push_back('{r: mr, d: md});
    end
    if (model_q.size() > max_count) max_count = model_q.size();

    checkOutput("rf_rd1", 64'(dut_rf[r1]), 64'(model_rf[r1]));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    model_err = 1'b0;
    max_count = 0;
    for (int i = 0; i < 32; i++) begin
      model_rf[i] = 32'h0;
      dut_rf[i]   = 32'h0;
    end
    reset = 1'b0;
    alu_valid = 1'b0;  alu_regn = '0;  alu_data = '0;
    mem_valid = 1'b0;  mem_regn = '0;  mem_data = '0;
    rd1n = '0;  rd2n = '0;
    repeat (2) @(posedge clk);

    // Held in reset, then released and idle.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h4, 5'd0, 5'd1, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd1, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd1, 1'b1);

    // Single ALU write, then let it drain.
    applyStimulus(1'b1, 5'd8, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd8, 5'd8, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd8, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd8, 5'd0, 1'b1);

    // Same-cycle ALU and mem writes to one register; forwarding sees 0x22.
    applyStimulus(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22, 5'd5, 5'd5, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b1);

    // Continuous ALU plus mem traffic fills the queue and throttles mem.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 5'(1 + i % 7), $urandom, 1'b1, 5'(9 + i % 7), $urandom,
                    5'(1 + i % 7), 5'(9 + i % 7), 1'b1);
    end

    // Register-0 writes are dropped from both sources.
    applyStimulus(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 32'hFFFF, 5'd0, 5'd0, 1'b1);
    applyStimulus(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd3, 32'h33, 5'd0, 5'd3, 1'b1);

    // Reset with entries queued: nothing stale commits afterwards.
    applyStimulus(1'b1, 5'd6, 32'h66, 1'b1, 5'd7, 32'h77, 5'd6, 5'd7, 1'b1);
    applyStimulus(1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 32'hAA, 5'd9, 5'd10, 1'b1);
    applyStimulus(1'b1, 5'd11, 32'hBB, 1'b1, 5'd12, 32'hCC, 5'd11, 5'd12, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd13, 32'hDD, 5'd9, 5'd10, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd10, 1'b1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd11, 5'd12, 1'b1);

    // Random traffic over a small register range to exercise forwarding.
    for (int i = 0; i < 1500; i++) begin
      applyStimulus(($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
                    ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom,
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                    ($urandom_range(0, 99) >= 2));
    end

    // Drain, then compare the whole register-file image.
    repeat (DEPTH + 1) applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b1);
    for (int i = 0; i < 32; i++) checkOutput($sformatf("rf_final%0d", i), 64'(dut_rf[i]), 64'(model_rf[i]));
    checkOutput("rf_reg0", 64'(dut_rf[0]), 64'h0);
    checkOutput("max_count_bound", 64'(max_count <= DEPTH), 64'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_write_queue.md
Name: regfile_write_queue

Overview:
Write-side front end for the 32x32 MIPS register file. Accepts writeback results from the ALU path (no backpressure) and the load/multiply path (valid/ready), buffers them in order in a small FIFO, and drains one entry per cycle onto the register file write port (wregn/wdata/wen). It also offers two forwarding lookups, so the read-operand stage sees values that are still queued but not yet committed.

Parameters:
DEPTH, 4, queue entries (power of two, >=2)
REGW, 5, register-number width
DATAW, 32, data width

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge)
alu_valid  input  1  ALU result present this cycle (no ready; must be accepted)
alu_regn  input  REGW  ALU destination register
alu_data  input  DATAW  ALU result
mem_valid  input  1  load/mult result present
mem_ready  output  1  queue accepts mem result this cycle
mem_regn  input  REGW  mem destination register
mem_data  input  DATAW  mem result
wregn  output  REGW  to register file write select
wdata  output  DATAW  to register file write data
wen  output  1  to register file write enable
rd1n  input  REGW  forwarding lookup 1 register number
fwd1_hit  output  1  youngest queued entry matches rd1n
fwd1_data  output  DATAW  data of that entry (0 if no hit)
rd2n  input  REGW  forwarding lookup 2 register number
fwd2_hit  output  1  as fwd1, for rd2n
fwd2_data  output  DATAW  as fwd1, for rd2n
count  output  $clog2(DEPTH)+1  occupied entries
err_ovf  output  1  sticky: ALU result lost to a full queue

Behaviour:
- Reset (reset==0 at clk edge): count=0, head/tail pointers=0, err_ovf=0. Storage contents are don't-care. While reset==0, mem_ready=0.
- Outputs are combinational from the head entry: wen = (count!=0); wregn/wdata = head entry when wen=1, else 0. The register file commits on the same edge that pops the head.
- Dequeue: exactly one entry per cycle whenever count!=0. There is no write-port stall.
- Latency: an entry enqueued into an empty queue at edge k drives wen during cycle k..k+1 and is written into the register file at edge k+1.
- Register 0: a valid result with regn==0 is accepted and discarded. It is not enqueued, does not affect count, and does not deassert ready.
- Free slots this cycle: free = DEPTH - count + (count!=0).
- ALU enqueue: if alu_valid and alu_regn!=0:
  - if free>=1, the entry is written at the tail;
  - otherwise the result is dropped and err_ovf is set to 1 (cleared only by reset).
- mem_ready = reset && (free - alu_take) >= 1, where alu_take = alu_valid && alu_regn!=0 && free>=1. mem_ready is combinational; a mem transfer occurs when mem_valid && mem_ready.
- Same-cycle enqueue of both sources: the ALU entry is placed first (older), the mem entry second. Up to 2 pushes and 1 pop happen per cycle. count_next = count + pushes - pop.
- Ordering: strict FIFO. Multiple queued writes to the same register all commit in order, so the last one wins in the register file.
- Forwarding:
  - search only entries currently stored (not this cycle's incoming results);
  - the youngest match wins, including the head being committed this cycle;
  - rdNn==0 gives hit=0 and data=0;
  - purely combinational.
- Pointers wrap modulo DEPTH; count saturates by construction and never exceeds DEPTH.
- Reset mid-operation: all queued entries are lost with no writes issued. wen=0 from the first cycle after the reset edge.

Decomposition:
- Package wbq_pkg:
  - REGW, DATAW, DEPTH defaults;
  - REG_ZERO = 5'd0;
  - entry typedef {regn, data};
  - pointer width function.
- Sub-module wbq_fwd_lookup: priority search from tail-1 back to head over the entry array; returns hit/data. Instantiated twice (rd1n, rd2n).

Test Plan:
1. Reset then idle -> wen=0, count=0, mem_ready=1, err_ovf=0, fwd1_hit=0.
2. Single ALU write alu_regn=8, alu_data=32'hDEADBEEF at edge k -> at cycle k+1 wen=1, wregn=8, wdata=DEADBEEF; after edge k+1 count=0 and regfile reg8 reads DEADBEEF.
3. Same cycle alu(5,32'h11) and mem(5,32'h22) -> commits 0x11 then 0x22 on consecutive edges; regfile reg5 ends at 0x22. fwd1 with rd1n=5 reports 0x22 while both are queued.
4. Fill: hold mem_valid with distinct regs while alu_valid is continuous with DEPTH=4 -> mem_ready drops when free-alu_take==0, count never exceeds 4, no err_ovf.
5. Overflow: force count=4 with no pop possible, then alu_valid (regn=3) -> result dropped, err_ovf=1 and sticky until reset. A write to regn=0 (data 0xFFFF) is never seen on wen, and regfile reg0 stays 0.
6. Reset asserted (reset=0) with 3 queued entries -> next cycle wen=0, count=0, mem_ready=0. After release, no stale writes appear.
